femsoc_mem: RTL and testbench
=============================

FEMSOC_MEM -- requirements
Module: femsoc_mem

Interface
REQ-001 Parameter MEM_WORDS, default 1536, RAM depth in 32-bit words.
REQ-002 Parameter CLKS_PER_BIT, default 104, UART bit period in clk cycles (minimum 2).
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 mem_addr  input  32  byte address from the CPU initiator.
REQ-006 mem_wdata  input  32  write data, byte lanes already replicated by the initiator.
REQ-007 mem_rstrb  input  1  read strobe, one cycle per read request.
REQ-008 mem_wmask  input  4  byte-lane write enables; nonzero marks a write cycle.
REQ-009 mem_rdata  output  32  registered read data.
REQ-010 leds  output  5  LED register contents.
REQ-011 uart_tx  output  1  serial transmit line, idle high.

Function
REQ-012 Region decode: mem_addr[22]=0 selects RAM; mem_addr[22]=1 selects the IO page.
REQ-013 RAM word index = mem_addr[31:2]; an index >= MEM_WORDS reads 32'h0 and ignores writes; mem_addr[1:0] ignored for indexing.
REQ-014 RAM write: at the rising edge with RAM selected, each byte lane i with mem_wmask[i]=1 takes mem_wdata[8i+7:8i]; other lanes unchanged.
REQ-015 Read latency exactly one cycle: mem_rdata updates at the edge where mem_rstrb=1 and is valid the following cycle.
REQ-016 mem_rdata holds its last value in every cycle with mem_rstrb=0.
REQ-017 Simultaneous mem_rstrb and nonzero mem_wmask to the same word: the write is performed, and mem_rdata returns the pre-write data (read-first).
REQ-018 IO register map (offset mem_addr[7:2]): 0 = LEDS (R/W, bits 4:0), 1 = UART_DATA (W, bits 7:0), 2 = UART_STATUS (R, bit0 = busy); other offsets read 0, writes ignored.
REQ-019 IO writes take effect only when mem_wmask[0]=1.
REQ-020 IO reads follow the same one-cycle latency as RAM; unused bits read 0.
REQ-021 UART TX FSM states: IDLE, START, DATA, STOP.
REQ-022 IDLE -> START on a UART_DATA write while busy=0; byte latched; busy=1 from the next cycle.
REQ-023 A UART_DATA write while busy=1 is dropped silently; the frame in progress is unaffected.
REQ-024 Frame format 8N1: START drives 0, then DATA drives bits 0..7 LSB first, then STOP drives 1; each bit lasts CLKS_PER_BIT cycles.
REQ-025 STOP -> IDLE after CLKS_PER_BIT cycles; busy clears in the same cycle; a new write may be accepted in the first IDLE cycle.
REQ-026 Frame length is exactly 10*CLKS_PER_BIT cycles, measured from the first START cycle to the first IDLE cycle.
REQ-027 The bit-period counter and the 3-bit data index wrap to 0 at each bit boundary and at the end of the frame.

Reset
REQ-028 rstn low asynchronously forces mem_rdata=0, leds=0, uart_tx=1, busy=0, FSM=IDLE, counters=0.
REQ-029 Reset asserted mid-frame aborts the frame immediately; after release the line stays high until a new UART_DATA write.
REQ-030 RAM contents are zero at power-up initialisation and are not modified by reset.

Verification
REQ-031 Write word 0x100 with 0xDEADBEEF, mask 1111; rstrb at 0x100 -> mem_rdata=0xDEADBEEF one cycle later.
REQ-032 Write 0x11111111 with mask 0100 to 0x104 after 0x00000000 -> readback 0x00110000; with mask 1100 -> 0x11110000.
REQ-033 rstrb and mask 1111 with 0x55 to a word holding 0xAA, same cycle -> mem_rdata=0xAA; next read -> 0x55.
REQ-034 CLKS_PER_BIT=4; write 0xA5 to UART_DATA (0x400004) -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy=1 for 40 cycles; a second write during the frame is dropped.
REQ-035 Write 0x1F to LEDS (0x400000), read 0x400000 -> leds=5'h1F, mem_rdata=0x1F; read 0x400008 mid-frame -> 0x1.
REQ-036 Assert rstn low at cycle 15 of a frame -> uart_tx=1 and leds=0 immediately; RAM word 0x100 still reads 0xDEADBEEF after release.

Source files
------------

// File: rtl/femsoc_mem.sv
// femsoc_mem: CPU-facing memory slave with a word-addressed RAM, an IO page
// holding an LED register, and a UART transmitter that sends 8N1 frames.
// Read data comes back one cycle after the read strobe and is held until
// the next strobe.
module femsoc_mem #(
    parameter int MEM_WORDS    = 1536,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_rstrb,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic [4:0]  leds,
    output logic        uart_tx
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    // UART transmitter states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // IO register offsets (word offsets within the IO page)
    localparam logic [5:0] IO_LEDS        = 6'd0;
    localparam logic [5:0] IO_UART_DATA   = 6'd1;
    localparam logic [5:0] IO_UART_STATUS = 6'd2;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        io_sel;
    logic        ram_sel;
    logic [29:0] word_idx;
    logic        ram_in_range;
    logic [AW-1:0] ram_idx;
    logic        wr_cycle;
    logic        ram_we;
    logic        ram_re;
    logic [5:0]  io_offset;
    logic        io_we;
    logic        leds_we;
    logic        uart_we;
    logic [1:0]  unused_addr_bits;

    assign io_sel           = mem_addr[22];
    assign ram_sel          = ~mem_addr[22];
    assign word_idx         = mem_addr[31:2];
    assign ram_in_range     = (word_idx < 30'(MEM_WORDS));
    assign ram_idx          = word_idx[AW-1:0];
    assign wr_cycle         = |mem_wmask;
    assign ram_we           = ram_sel & ram_in_range & wr_cycle;
    assign ram_re           = ram_sel & ram_in_range & mem_rstrb;
    assign io_offset        = mem_addr[7:2];
    // IO registers are at most a byte wide, so only lane 0 commits a write
    assign io_we            = io_sel & mem_wmask[0];
    assign leds_we          = io_we & (io_offset == IO_LEDS);
    assign uart_we          = io_we & (io_offset == IO_UART_DATA);
    // byte offset within a word plays no part in indexing
    assign unused_addr_bits = mem_addr[1:0];

    // ------------------------------------------------------------------
    // RAM: byte-lane writes, read-first registered read, no reset so the
    // array maps onto block RAM. Contents start at zero.
    // ------------------------------------------------------------------
    logic [31:0] ram_mem [MEM_WORDS] = '{default: 32'h0};
    logic [31:0] ram_rd_reg;

    // Read-first port: the old word is captured even when the same edge writes it
    always_ff @(posedge clk) begin
        if (ram_re) begin
            ram_rd_reg <= ram_mem[ram_idx];
        end
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i]) begin
                    ram_mem[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // IO registers and read mux
    // ------------------------------------------------------------------
    logic [4:0]  leds_reg;
    logic        busy;
    logic [31:0] io_rdata;
    logic [31:0] io_rd_reg;
    logic        rd_ram_sel_reg;

    // LED register, written from the low byte lane
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            leds_reg <= 5'h0;
        end else if (leds_we) begin
            leds_reg <= mem_wdata[4:0];
        end
    end

    // IO read value, zero in every unused bit and at every unmapped offset
    always_comb begin
        io_rdata = 32'h0;
        case (io_offset)
            IO_LEDS:        io_rdata[4:0] = leds_reg;
            IO_UART_STATUS: io_rdata[0]   = busy;
            default:        io_rdata      = 32'h0;
        endcase
    end

    // Capture the non-RAM read result and remember which source answered;
    // out-of-range RAM reads fall into the zero path
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ram_sel_reg <= 1'b0;
            io_rd_reg      <= 32'h0;
        end else if (mem_rstrb) begin
            rd_ram_sel_reg <= ram_sel & ram_in_range;
            io_rd_reg      <= io_sel ? io_rdata : 32'h0;
        end
    end

    // Both sources only change on a strobe, so the output holds between reads
    assign mem_rdata = rd_ram_sel_reg ? ram_rd_reg : io_rd_reg;
    assign leds      = leds_reg;

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg,   cnt_next;
    logic [2:0]    idx_reg,   idx_next;
    logic [7:0]    data_reg,  data_next;
    logic          tx_reg,    tx_next;
    logic          bit_done;

    assign busy     = (state_reg != ST_IDLE);
    assign bit_done = (cnt_reg == CNT_LAST);

    // Next-state logic: one bit period per START/DATA-bit/STOP, counters wrap at each boundary
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                idx_next = 3'd0;
                if (uart_we) begin
                    state_next = ST_START;
                    data_next  = mem_wdata[7:0];
                end
            end
            ST_START: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (idx_reg == 3'd7) begin
                        idx_next   = 3'd0;
                        state_next = ST_STOP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                idx_next   = 3'd0;
            end
        endcase
    end

    // Line level for the upcoming state, registered so uart_tx is glitch-free
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = data_next[idx_next];
            default:  tx_next = 1'b1;
        endcase
    end

    // Transmitter state registers; reset aborts any frame and idles the line high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= 3'd0;
            data_reg  <= 8'h0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            tx_reg    <= tx_next;
        end
    end

    assign uart_tx = tx_reg;

endmodule

// File: tb/tb_femsoc_mem.sv
// tb_femsoc_mem: directed plus randomized checks of femsoc_mem against a
// cycle-indexed reference model (word array, LED value, frame start time).
module tb_femsoc_mem;

    localparam int MW  = 1536;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_rstrb = 1'b0;
    logic [3:0]  mem_wmask = 4'h0;
    wire  [31:0] mem_rdata;
    wire  [4:0]  leds;
    wire         uart_tx;

    femsoc_mem #(.MEM_WORDS(MW), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rstrb (mem_rstrb),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .leds      (leds),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] ref_mem [MW];
    logic [4:0]  ref_leds;
    logic [31:0] ref_rdata;
    int          cyc;     // index of the cycle currently being observed
    int          fs;      // first START cycle of the latest frame, -1 if none
    logic [7:0]  fbyte;
    int          ncmp;
    int          nfail;

    function automatic bit ref_busy(int c);
        return (fs >= 0) && (c >= fs) && (c < fs + 10 * CPB);
    endfunction

    // Expected line level: frame bit n = {start 0, d0..d7, stop 1}
    function automatic logic ref_tx(int c);
        int b;
        if (!ref_busy(c)) return 1'b1;
        b = (c - fs) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return fbyte[b-1];
        return 1'b1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock with the current inputs; model predicts, then outputs are checked
    task automatic step();
        int w;
        logic [31:0] rd;
        w = int'(mem_addr[31:2]);
        if (mem_rstrb) begin
            rd = 32'h0;
            if (!mem_addr[22]) begin
                if (w < MW) rd = ref_mem[w];
            end else begin
                if (mem_addr[7:2] == 6'd0) rd = {27'h0, ref_leds};
                else if (mem_addr[7:2] == 6'd2) rd = {31'h0, ref_busy(cyc)};
            end
            ref_rdata = rd;
        end
        if ((mem_wmask != 4'h0) && !mem_addr[22] && (w < MW)) begin
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) ref_mem[w][8*i +: 8] = mem_wdata[8*i +: 8];
        end
        if (mem_addr[22] && mem_wmask[0]) begin
            if (mem_addr[7:2] == 6'd0) ref_leds = mem_wdata[4:0];
            if (mem_addr[7:2] == 6'd1 && !ref_busy(cyc)) begin
                fs    = cyc + 1;
                fbyte = mem_wdata[7:0];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("rdata", mem_rdata, ref_rdata);
        chk("leds", {27'h0, leds}, {27'h0, ref_leds});
        chk("uart_tx", {31'h0, uart_tx}, {31'h0, ref_tx(cyc)});
    endtask

    task automatic idle();
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_rstrb = 1'b0;
        mem_wmask = 4'h0;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] m);
        mem_addr = a; mem_wdata = d; mem_rstrb = 1'b0; mem_wmask = m;
        step();
        $display("write addr=%08h data=%08h mask=%b", a, d, m);
        idle();
    endtask

    task automatic rd(logic [31:0] a);
        mem_addr = a; mem_wdata = 32'h0; mem_rstrb = 1'b1; mem_wmask = 4'h0;
        step();
        $display("read  addr=%08h rdata=%08h model=%08h", a, mem_rdata, ref_rdata);
        idle();
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic pulse_reset();
        #2;
        rstn = 1'b0;
        #1;
        ref_leds  = 5'h0;
        ref_rdata = 32'h0;
        fs        = -1;
        chk("rst_tx", {31'h0, uart_tx}, 32'h1);
        chk("rst_leds", {27'h0, leds}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rstn = 1'b1;
        $display("reset pulse at cycle %0d", cyc);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        int          sel;
        ncmp = 0; nfail = 0; cyc = 0; fs = -1;
        fbyte = 8'h0; ref_leds = 5'h0; ref_rdata = 32'h0;
        for (int i = 0; i < MW; i++) ref_mem[i] = 32'h0;

        // Power-on reset
        repeat (2) begin @(posedge clk); cyc++; end
        #1;
        chk("por_rdata", mem_rdata, 32'h0);
        chk("por_leds", {27'h0, leds}, 32'h0);
        chk("por_tx", {31'h0, uart_tx}, 32'h1);
        rstn = 1'b1;
        step();

        // Full-word write and readback
        wr(32'h100, 32'hDEADBEEF, 4'hF);
        rd(32'h100);
        // Partial byte-lane writes
        wr(32'h104, 32'h0, 4'hF);
        wr(32'h104, 32'h11111111, 4'b0100);
        rd(32'h104);
        wr(32'h104, 32'h11111111, 4'b1100);
        rd(32'h104);
        // Same-cycle read and write: old data returned
        wr(32'h108, 32'hAA, 4'hF);
        mem_addr = 32'h108; mem_wdata = 32'h55; mem_rstrb = 1'b1; mem_wmask = 4'hF;
        step();
        $display("rmw   addr=00000108 rdata=%08h model=%08h", mem_rdata, ref_rdata);
        idle();
        rd(32'h108);
        // Hold between strobes
        repeat (3) step();

        // Depth boundary: last word, first out-of-range word, aliasing index
        wr(32'h17FC, 32'hCAFEF00D, 4'hF);
        rd(32'h17FC);
        wr(32'h1800, 32'h12345678, 4'hF);
        rd(32'h1800);
        wr(32'h2000, 32'h87654321, 4'hF);
        rd(32'h0);

        // Randomized RAM traffic
        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                7:       a = 32'(1535) << 2;
                8:       a = 32'(1536) << 2;
                9:       a = 32'(2048 + $urandom_range(0, 3)) << 2;
                default: a = 32'($urandom_range(0, 15)) << 2;
            endcase
            a[1:0]    = 2'($urandom_range(0, 3));
            d         = $urandom;
            m         = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            mem_addr  = a; mem_wdata = d; mem_wmask = m;
            mem_rstrb = 1'($urandom_range(0, 1));
            step();
            $display("rand  addr=%08h data=%08h mask=%b rstrb=%0d rdata=%08h model=%08h",
                     a, d, m, mem_rstrb, mem_rdata, ref_rdata);
            idle();
        end

        // LED register
        wr(32'h400000, 32'h1F, 4'b0001);
        rd(32'h400000);
        wr(32'h400000, 32'h03, 4'b1110);
        rd(32'h400000);
        wr(32'h40000C, 32'hFF, 4'b0001);
        rd(32'h40000C);

        // UART frame 0xA5 with a dropped write and a status read mid-frame
        wr(32'h400004, 32'hA5, 4'b0001);
        repeat (8) step();
        wr(32'h400004, 32'h3C, 4'b0001);
        rd(32'h400008);
        while (cyc < fs + 10 * CPB + 2) step();
        rd(32'h400008);

        // Back-to-back frames: next write lands in the first idle cycle
        wr(32'h400004, 32'($urandom_range(0, 255)), 4'b0001);
        while (cyc < fs + 10 * CPB - 1) step();
        rd(32'h400008);
        wr(32'h400004, 32'($urandom_range(0, 255)), 4'b0001);
        while (cyc < fs + 10 * CPB + 1) step();

        // Reset at cycle 15 of a frame
        wr(32'h400000, 32'h15, 4'b0001);
        wr(32'h400004, 32'($urandom_range(0, 255)), 4'b0001);
        while (cyc < fs + 15) step();
        pulse_reset();
        repeat (12) step();
        rd(32'h400008);
        rd(32'h100);
        rd(32'h400000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    // Safety bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
